int2flt_seq: RTL
================

INT2FLT_SEQ -- requirements
Module: int2flt_seq

Interface
REQ-001 INT_W, 8, sign-magnitude integer width (bit 7 sign, bits 6:0 magnitude); only 8 supported.
REQ-002 EXP_W, 4, unsigned exponent width; only 4 supported.
REQ-003 FRAC_W, 8, fraction width; only 8 supported.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_data  input  8  sign-magnitude integer.
REQ-008 in_ready  output  1  block can accept a new integer.
REQ-009 out_valid  output  1  out_flt holds a finished result.
REQ-010 out_flt  output  12  {sign[11], exp[10:7], frac[7:0]} in output bits [11:0], value = 0.frac x 2^exp.
REQ-011 out_ready  input  1  downstream (float-to-int stage) accepts out_flt.

Function
REQ-012 The block SHALL convert in_data to a normalized float: frac[7]=1 for nonzero magnitude, exp = bit index of leading 1 of magnitude plus 1 (range 1..7).
REQ-013 Zero magnitude SHALL produce exp=0, frac=0x00, sign copied from in_data[7] (negative zero preserved).
REQ-014 Sign SHALL always be copied unchanged; no rounding occurs (conversion is exact).
REQ-015 States SHALL be IDLE, NORM, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE: on in_valid&&in_ready SHALL capture sign, frac={in_data[6:0],1'b0}, exp=7, go to NORM.
REQ-017 NORM: if frac==0 SHALL set exp=0 and go to DONE; else if frac[7]==1 SHALL go to DONE; else SHALL shift frac left by 1 and decrement exp by 1, staying in NORM.
REQ-018 Latency SHALL be 2 + (7 - exp) cycles from accept edge to out_valid high (zero: 2 cycles); exp SHALL never wrap below 1 for nonzero input.
REQ-019 DONE: out_flt SHALL be held stable while out_valid=1 and out_ready=0; on out_ready=1 SHALL return to IDLE next edge.
REQ-020 No same-cycle bypass: in_ready SHALL be 0 in the cycle out_valid&&out_ready handshakes; next input accepted earliest one cycle later.
REQ-021 in_data SHALL be ignored outside IDLE; in_valid without in_ready SHALL not change state.

Reset
REQ-022 reset SHALL asynchronously force state IDLE, out_valid=0, out_flt=0x000, in_ready=1 after release, regardless of state.
REQ-023 Reset asserted mid-NORM or mid-DONE SHALL discard the in-flight result; no out_valid pulse after release.

Configuration
REQ-024 Macro INT2FLT_LZD_EN: when defined, normalization SHALL be single-cycle via leading-zero detector; IDLE accept goes directly to DONE, out_valid high 1 cycle after accept for all inputs, NORM unused.
REQ-025 Without INT2FLT_LZD_EN, the iterative shifter of REQ-016..018 SHALL be used; results bit-identical in both builds.

Structure
REQ-026 Package int2flt_pkg SHALL hold INT_W/EXP_W/FRAC_W constants, state enum (IDLE, NORM, DONE), and the float field bit positions.
REQ-027 Sub-module int2flt_lzd (7-bit priority encoder: magnitude -> leading-zero count 0..7) SHALL be instantiated only under INT2FLT_LZD_EN.

Verification
REQ-028 in_data=0x01, out_ready=1 -> out_flt={0,0001,0x80}; out_valid at cycle 8 (iterative) / cycle 1 (LZD).
REQ-029 in_data=0xFF -> out_flt={1,0111,0xFE}, out_valid at cycle 2 / cycle 1.
REQ-030 in_data=0x80 (negative zero) -> out_flt={1,0000,0x00} at cycle 2 / cycle 1.
REQ-031 in_data=0x05, out_ready=0 for 10 cycles then 1 -> out_flt={0,0011,0xA0} held stable, in_ready=0 until one cycle after handshake.
REQ-032 in_data=0x03 accepted, reset pulsed at cycle 3 -> out_valid=0, out_flt=0x000, in_ready=1; next 0x40 -> {0,0111,0x80}.
REQ-033 Exhaustive 0x00..0xFF sweep -> each result fed to float-to-int stage returns original in_data, uf=1 only for zero magnitude, of=0 always.

Source files
------------

// File: rtl/int2flt_pkg.sv
// -----------------------------------------------------------------------------
// int2flt_pkg
// Shared constants, state encoding and float packing helper for the
// integer-to-float converter (int2flt_seq) and its leading-zero detector.
//
// Float word layout (FLT_W = 12 bits):
//   [11]   sign
//   [10:7] exponent, value = 0.frac x 2^exp
//   [6:0]  fraction bits below the leading one
// The fraction is normalized, so frac[7] is 1 whenever exp != 0 and 0 for a
// zero result. That bit is therefore implied by the exponent and is not
// stored, which lets the 1 + 4 + 8 bit float fit into the 12-bit word.
// -----------------------------------------------------------------------------
package int2flt_pkg;

    localparam int INT_W  = 8;              // sign-magnitude integer width
    localparam int EXP_W  = 4;              // unsigned exponent width
    localparam int FRAC_W = 8;              // fraction width including the leading one
    localparam int MAG_W  = INT_W - 1;      // magnitude bits of the integer
    localparam int LZC_W  = 3;              // leading-zero count width (0..7)
    localparam int FLT_W  = 1 + EXP_W + FRAC_W - 1;

    // Float field bit positions
    localparam int SIGN_BIT = 11;
    localparam int EXP_MSB  = 10;
    localparam int EXP_LSB  = 7;
    localparam int FRAC_MSB = 6;
    localparam int FRAC_LSB = 0;

    localparam logic [EXP_W-1:0] EXP_MAX  = 4'd7;   // exponent of a magnitude with bit 6 set
    localparam logic [EXP_W-1:0] EXP_ONE  = 4'd1;
    localparam logic [EXP_W-1:0] EXP_ZERO = 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_e;

    // Pack sign, exponent and the stored fraction bits into the float word
    function automatic logic [FLT_W-1:0] flt_pack(
        input logic                sign,
        input logic [EXP_W-1:0]    exp,
        input logic [FRAC_W-2:0]   frac_lo
    );
        logic [FLT_W-1:0] flt;
        flt                     = {FLT_W{1'b0}};
        flt[SIGN_BIT]           = sign;
        flt[EXP_MSB:EXP_LSB]    = exp;
        flt[FRAC_MSB:FRAC_LSB]  = frac_lo;
        return flt;
    endfunction

endpackage

// File: rtl/int2flt_lzd.sv
// -----------------------------------------------------------------------------
// int2flt_lzd
// 7-bit priority encoder: counts leading zeros of the integer magnitude.
// A zero magnitude returns 7.
//
// Ports:
//   mag  in   [MAG_W-1:0]  integer magnitude
//   lzc  out  [LZC_W-1:0]  number of zeros above the leading one (0..7)
// -----------------------------------------------------------------------------
module int2flt_lzd
    import int2flt_pkg::*;
(
    input  logic [MAG_W-1:0] mag,
    output logic [LZC_W-1:0] lzc
);

    // Priority encode from the MSB downwards
    always_comb begin
        lzc = 3'd7;
        casez (mag)
            7'b1??????: lzc = 3'd0;
            7'b01?????: lzc = 3'd1;
            7'b001????: lzc = 3'd2;
            7'b0001???: lzc = 3'd3;
            7'b00001??: lzc = 3'd4;
            7'b000001?: lzc = 3'd5;
            7'b0000001: lzc = 3'd6;
            default:    lzc = 3'd7;
        endcase
    end

endmodule

// File: rtl/int2flt_seq.sv
// -----------------------------------------------------------------------------
// int2flt_seq
// Converts an 8-bit sign-magnitude integer into a normalized float
// {sign, exp, frac} with value 0.frac x 2^exp. The conversion is exact.
// Ready/valid handshake on both sides; one conversion in flight at a time.
//
// Build option:
//   INT2FLT_LZD_EN  when defined, normalization is done in one step with a
//                   leading-zero detector and the result is valid one cycle
//                   after accept. Otherwise an iterative shifter normalizes
//                   one bit per cycle. Both builds give identical results.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   in_valid   in   in_data is valid
//   in_data    in   [7:0]  sign-magnitude integer (bit 7 sign)
//   in_ready   out  block can accept a new integer (IDLE only)
//   out_valid  out  out_flt holds a finished result (DONE only)
//   out_flt    out  [11:0] {sign, exp[3:0], frac[6:0]}, frac[7] implied by exp != 0
//   out_ready  in   downstream accepts out_flt
// -----------------------------------------------------------------------------
module int2flt_seq
    import int2flt_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [INT_W-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [FLT_W-1:0] out_flt,
    input  logic             out_ready
);

    state_e           state_r;
    state_e           state_nxt_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [FLT_W-1:0] out_flt_r;
    logic             flt_load_s;
    logic [FLT_W-1:0] flt_nxt_s;

`ifdef INT2FLT_LZD_EN
    logic [LZC_W-1:0] lzc_s;
    logic [MAG_W-1:0] mag_shift_s;
    logic [EXP_W-1:0] lzd_exp_s;

    int2flt_lzd u_lzd (
        .mag (in_data[MAG_W-1:0]),
        .lzc (lzc_s)
    );

    // Single-step normalization: shift the leading one up to the top bit
    always_comb begin
        mag_shift_s = in_data[MAG_W-1:0] << lzc_s;
        if (mag_shift_s[MAG_W-1]) begin
            lzd_exp_s = EXP_MAX - {1'b0, lzc_s};
        end else begin
            lzd_exp_s = EXP_ZERO;
        end
    end
`else
    logic              sign_r;
    logic [EXP_W-1:0]  exp_r;
    logic [FRAC_W-1:0] frac_r;
    logic              sign_nxt_s;
    logic [EXP_W-1:0]  exp_nxt_s;
    logic [FRAC_W-1:0] frac_nxt_s;
`endif

    // Next-state, datapath and result-load decisions
    always_comb begin
        state_nxt_s = state_r;
        flt_load_s  = 1'b0;
        flt_nxt_s   = out_flt_r;
`ifndef INT2FLT_LZD_EN
        sign_nxt_s  = sign_r;
        exp_nxt_s   = exp_r;
        frac_nxt_s  = frac_r;
`endif
        case (state_r)
            IDLE: begin
                if (in_valid) begin
`ifdef INT2FLT_LZD_EN
                    state_nxt_s = DONE;
                    flt_load_s  = 1'b1;
                    flt_nxt_s   = flt_pack(in_data[INT_W-1], lzd_exp_s,
                                           {mag_shift_s[MAG_W-2:0], 1'b0});
`else
                    // Start with the magnitude under the binary point at 2^7
                    state_nxt_s = NORM;
                    sign_nxt_s  = in_data[INT_W-1];
                    frac_nxt_s  = {in_data[MAG_W-1:0], 1'b0};
                    exp_nxt_s   = EXP_MAX;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
`ifndef INT2FLT_LZD_EN
            NORM: begin
                if (frac_r == 8'h00) begin
                    state_nxt_s = DONE;
                    exp_nxt_s   = EXP_ZERO;
                    flt_load_s  = 1'b1;
                    flt_nxt_s   = flt_pack(sign_r, EXP_ZERO, 7'h00);
                end else if (frac_r[FRAC_W-1]) begin
                    state_nxt_s = DONE;
                    flt_load_s  = 1'b1;
                    flt_nxt_s   = flt_pack(sign_r, exp_r, frac_r[FRAC_W-2:0]);
                end else begin
                    // Leading one is at most 6 shifts away, so exp stops at 1
                    state_nxt_s = NORM;
                    frac_nxt_s  = {frac_r[FRAC_W-2:0], 1'b0};
                    exp_nxt_s   = exp_r - EXP_ONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Control state and registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_flt_r   <= 12'h000;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
            if (flt_load_s) begin
                out_flt_r <= flt_nxt_s;
            end else begin
                out_flt_r <= out_flt_r;
            end
        end
    end

`ifndef INT2FLT_LZD_EN
    // Iterative normalization working registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_r <= 1'b0;
            exp_r  <= 4'd0;
            frac_r <= 8'h00;
        end else begin
            sign_r <= sign_nxt_s;
            exp_r  <= exp_nxt_s;
            frac_r <= frac_nxt_s;
        end
    end
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_flt   = out_flt_r;

endmodule
